// File: rtl/tdc_uart_packetizer.sv
// rtl/tdc_uart_packetizer.sv - buffers 40-bit TDC words in a FIFO and sends each as an 8N1 UART byte packet (optional XOR checksum byte via TDC_PKT_CHECKSUM_EN)
module tdc_uart_packetizer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [39:0]                   data,
  input  logic                          valid,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef TDC_PKT_CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam int SW = NBYTES * 8;

  localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BYTE_LAST = 3'(NBYTES - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE   = 1;
  localparam logic [PW-1:0] PTR_ONE   = 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [39:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q;

  state_t        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_idx_q;
  logic [2:0]    byte_idx_q;
  logic [SW-1:0] shift_q;
  logic          tx_q;

  logic          pop;
  logic          push;
  logic          bit_end;
  logic [7:0]    cur_byte;
  logic [2:0]    next_bit_idx;
  logic [39:0]   head_word;
  logic [SW-1:0] load_word;

  // The head is only popped from IDLE, so a word written this cycle is seen at the earliest next cycle.
  assign pop          = (state_q == S_IDLE) && (count_q != '0);
  assign push         = valid && ((count_q != DEPTH_C) || pop);
  assign bit_end      = (baud_q == BIT_LAST);
  assign cur_byte     = shift_q[SW-1 -: 8];
  assign next_bit_idx = bit_idx_q + 3'd1;
  assign head_word    = mem_q[rd_ptr_q];

`ifdef TDC_PKT_CHECKSUM_EN
  assign load_word = {head_word, head_word[39:32] ^ head_word[31:24] ^ head_word[23:16]
                                 ^ head_word[15:8] ^ head_word[7:0]};
`else
  assign load_word = head_word;
`endif

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  // FIFO pointers, occupancy and the sticky dropped-word flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      if (valid && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // UART framer: tx is registered and updated together with each state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q    <= load_word;
            byte_idx_q <= '0;
            baud_q     <= '0;
            tx_q       <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= next_bit_idx;
              tx_q      <= cur_byte[next_bit_idx];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (byte_idx_q != BYTE_LAST) begin
              byte_idx_q <= byte_idx_q + 3'd1;
              shift_q    <= {shift_q[SW-9:0], 8'h00};
              tx_q       <= 1'b0;
              state_q    <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_tdc_uart_packetizer.sv
// tb/tb_tdc_uart_packetizer.sv - scoreboard bench for tdc_uart_packetizer with a packet-level reference model and UART receiver
module tb_tdc_uart_packetizer;

  localparam int C  = 4;
  localparam int D  = 4;
`ifdef TDC_PKT_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int PKT = NB * 10 * C;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [39:0] data  = '0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [$clog2(D):0] fifo_count;

  tdc_uart_packetizer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .valid      (valid),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packet byte k of a word: bytes MSB first, then the XOR checksum when enabled.
  function automatic logic [7:0] pkt_byte(input logic [39:0] w, input int k);
    logic [7:0] x;
    x = '0;
    if (k < 5) return 8'((w >> (8 * (4 - k))) & 40'hFF);
    for (int j = 0; j < 5; j++) x ^= 8'((w >> (8 * j)) & 40'hFF);
    return x;
  endfunction

  // Reference model: a queue of stored words and a packet timer; a packet lasts PKT cycles
  // and the next one can begin after one idle cycle.
  logic [39:0] m_fifo[$];
  int          m_rem     = 0;
  bit          m_ovf     = 1'b0;
  int          m_pop_cyc = 0;
  logic [7:0]  exp_bytes[$];
  int          exp_start[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_fifo.delete();
      exp_bytes.delete();
      exp_start.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      cyc++;
      if (m_rem > 0) begin
        m_rem--;
      end else if (m_fifo.size() > 0) begin
        void'(m_fifo.pop_front());
        m_rem     = PKT;
        m_pop_cyc = cyc;
        for (int k = 0; k < NB; k++) exp_start.push_back(cyc + k * 10 * C);
      end
      if (valid) begin
        if (m_fifo.size() < D) begin
          m_fifo.push_back(data);
          for (int k = 0; k < NB; k++) exp_bytes.push_back(pkt_byte(data, k));
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: UART receiver sampling mid-bit; pops the scoreboard on every received byte.
  bit         rx_on = 1'b0;
  int         rx_t  = 0;
  int         rx_i  = 0;
  logic [7:0] rx_byte = '0;

  always @(negedge clk) begin
    if (reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_t  = 0;
        check("start_expected", exp_start.size() > 0, 1);
        if (exp_start.size() > 0) check("start_cycle", cyc, exp_start.pop_front());
      end
    end else begin
      rx_t++;
      if (rx_t % C == C / 2) begin
        rx_i = rx_t / C;
        if (rx_i == 0) begin
          check("start_bit", tx, 0);
        end else if (rx_i <= 8) begin
          rx_byte = {tx, rx_byte[7:1]};
        end else begin
          check("stop_bit", tx, 1);
          check("byte_expected", exp_bytes.size() > 0, 1);
          if (exp_bytes.size() > 0) check("rx_byte", rx_byte, exp_bytes.pop_front());
          rx_on = 1'b0;
        end
      end
    end
  end

  // Status outputs against the model on every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      check("fifo_count", fifo_count, m_fifo.size());
      check("busy", busy, (m_rem > 0) || (m_fifo.size() > 0));
      check("overflow", overflow, m_ovf);
      if (m_rem == 0) check("tx_idle_high", tx, 1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [39:0] w);
    valid = 1'b1;
    data  = w;
    step(1);
    valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((m_rem > 0 || m_fifo.size() > 0 || rx_on) && k < 20000) begin
      step(1);
      k++;
    end
    check(name, k < 20000, 1);
    step(2 * C);
    check({name, "_busy"}, busy, 0);
    check({name, "_tx"}, tx, 1);
    check({name, "_count"}, fifo_count, 0);
  endtask

  logic [39:0] w;
  logic [7:0]  b;
  int          t0;
  int          k;
  int          gap;

  initial begin
    // Reset state
    step(3);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", fifo_count, 0);
    reset = 1'b0;
    step(2);

    // Single word: busy spans the push cycle plus one full packet
    pulse(40'h12_3456_7895);
    t0 = cyc;
    k  = 0;
    while (busy && k < 5000) begin step(1); k++; end
    check("single_busy_span", cyc - t0, PKT + 1);
    drain("single_drain");

    // Overflow: A in flight, B..E fill the FIFO, F is dropped
    pulse(40'hA0_A1A2_A3A4);
    step(2);
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      data  = {8'hB0 + 8'(i), 32'h0102_0304 * (i + 1)};
      step(1);
    end
    valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_count_full", fifo_count, D);
    drain("ovf_drain");
    check("ovf_sticky", overflow, 1);

    // Reset mid-frame: during data bit 3 of byte 2
    w = 40'hC3_5A96_E10F;
    pulse(w);
    step(1);
    step(24 * C + 1);
    b = pkt_byte(w, 2);
    check("mid_frame_bit", tx, b[3]);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_count", fifo_count, 0);
    check("async_rst_overflow", overflow, 0);
    step(2);
    reset = 1'b0;
    step(100);
    check("post_rst_tx", tx, 1);
    check("post_rst_busy", busy, 0);

    // Push in the same cycle as the IDLE pop with a full FIFO
    pulse(40'h11_2233_4455);
    step(2);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1;
      data  = {8'h20 + 8'(i), 32'hDEAD_BEEF ^ (32'h1111_1111 * i)};
      step(1);
    end
    valid = 1'b0;
    check("pp_full", fifo_count, D);
    k = 0;
    while (!(m_rem == 0 && m_fifo.size() == D) && k < 5000) begin step(1); k++; end
    check("pp_reach_idle", k < 5000, 1);
    pulse(40'h99_8877_6655);
    check("pp_count_held", fifo_count, D);
    check("pp_no_overflow", overflow, 0);
    drain("pp_drain");

    // Back-to-back: two words on consecutive cycles
    valid = 1'b1;
    data  = 40'h01_2345_6789;
    step(1);
    data  = 40'hFE_DCBA_9876;
    step(1);
    valid = 1'b0;
    k = 0;
    while (tx !== 1'b0 && k < 100) begin step(1); k++; end
    t0 = cyc;
    k  = 0;
    while (busy && k < 5000) begin step(1); k++; end
    check("b2b_total", cyc - t0, 2 * PKT + 1);
    drain("b2b_drain");

    // Randomized words, gaps and bursts
    for (int i = 0; i < 40; i++) begin
      w = {8'($urandom()), $urandom()};
      pulse(w);
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, PKT + 20);
      if (gap > 0) step(gap);
    end
    drain("rand_drain");
    check("sb_bytes_empty", exp_bytes.size(), 0);
    check("sb_starts_empty", exp_start.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
